// File: rtl/alu_md.sv
// EX-stage execution unit: single-cycle integer ALU plus an iterative
// multiply/divide engine that owns the architectural HI/LO registers.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d, div0_q, div0_d;

  logic [WIDTH-1:0] sum, diff;
  logic             is_md_op, signed_op, sa, sb, start;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_r;
  logic             div_ge;
  logic [WIDTH-1:0] step_acc, step_sh, quo, rem;
  logic [2*WIDTH-1:0] prod;

  // Single-cycle ALU
  assign sum  = a_in + b_in;
  assign diff = a_in - b_in;
  assign zero = (a_in == b_in);
  assign overflow = (alu_op == 4'b0101) && (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                    (sum[WIDTH-1] != a_in[WIDTH-1]);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000, 4'b0101: alu_result = sum;
      4'b0001: alu_result = diff;
      4'b0010: alu_result = a_in | b_in;
      4'b0011: alu_result = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      4'b0100: alu_result = b_in;
      4'b0110: alu_result = a_in & b_in;
      4'b0111: alu_result = a_in ^ b_in;
      4'b1000: alu_result = ~(a_in | b_in);
      4'b1001: alu_result = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
      4'b1110: alu_result = hi_q;
      4'b1111: alu_result = lo_q;
      default: alu_result = '0;
    endcase
  end

  // 1010 mult, 1011 multu, 1100 div, 1101 divu: bit0 clear means signed
  assign is_md_op  = (alu_op >= 4'b1010) && (alu_op <= 4'b1101);
  assign signed_op = ~alu_op[0];
  assign sa        = signed_op & a_in[WIDTH-1];
  assign sb        = signed_op & b_in[WIDTH-1];
  assign mag_a     = sa ? -a_in : a_in;
  assign mag_b     = sb ? -b_in : b_in;
  assign start     = (state_q == S_IDLE) && op_valid && is_md_op;

  // One iteration: shift-add multiply into {acc,sh}, or restoring divide
  // with the remainder in acc and dividend/quotient bits shifting through sh.
  assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
  assign div_r    = {acc_q, sh_q[WIDTH-1]};
  assign div_ge   = (div_r >= {1'b0, opb_q});
  assign step_acc = is_div_q ? (div_ge ? div_r[WIDTH-1:0] - opb_q : div_r[WIDTH-1:0])
                             : mul_sum[WIDTH:1];
  assign step_sh  = is_div_q ? {sh_q[WIDTH-2:0], div_ge}
                             : {mul_sum[0], sh_q[WIDTH-1:1]};

  // With a zero divisor the remainder path naturally ends holding the
  // dividend (sign restored below), so only the quotient needs forcing.
  assign prod = neg_res_q ? -{step_acc, step_sh} : {step_acc, step_sh};
  assign quo  = div0_q ? '1 : (neg_res_q ? -step_sh : step_sh);
  assign rem  = neg_rem_q ? -step_acc : step_acc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = CNT_LOAD;
          acc_d     = '0;
          sh_d      = mag_a;
          opb_d     = mag_b;
          is_div_d  = alu_op[2];
          neg_res_d = sa ^ sb;
          neg_rem_d = sa & alu_op[2];
          div0_d    = (b_in == '0);
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        acc_d = step_acc;
        sh_d  = step_sh;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          hi_d    = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
          lo_d    = is_div_q ? quo : prod[WIDTH-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: 32-bit and 16-bit instances, HI/LO results
// checked through an expectation queue popped on each done pulse.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [3:0]  alu_op = 4'b0000;
  logic [31:0] a_in = '0, b_in = '0;
  logic [31:0] alu_result, hi, lo;
  logic        zero, overflow, busy, done;

  logic        op_valid16 = 1'b0;
  logic [3:0]  alu_op16 = 4'b0000;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] res16, hi16, lo16;
  logic        zero16, ovf16, busy16, done16;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [31:0] last_lo = '0;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .alu_op(alu_op),
    .a_in(a_in), .b_in(b_in), .alu_result(alu_result), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo));

  alu_md #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .op_valid(op_valid16), .alu_op(alu_op16),
    .a_in(a16), .b_in(b16), .alu_result(res16), .zero(zero16),
    .overflow(ovf16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] oh, input logic [31:0] ol);
    logic [63:0] e;
    chk({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, {32'h0, oh}, {32'h0, e[63:32]});
      chk({tag, "_lo"}, {32'h0, ol}, {32'h0, e[31:0]});
      last_lo = e[31:0];
    end
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic eo);
    alu_op = op; a_in = a; b_in = b;
    #1;
    chk({tag, "_res"}, {32'h0, alu_result}, {32'h0, er});
    chk({tag, "_ovf_zero"}, {62'h0, overflow, zero}, {62'h0, eo, (a == b)});
  endtask

  task automatic do_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    @(negedge clk);
    op_valid = 1'b1; alu_op = op; a_in = a; b_in = b;
    sb_q.push_back({eh, el});
    @(posedge clk); #1;
    op_valid = 1'b0; alu_op = 4'b0000;
    chk({tag, "_busy_start"}, {63'h0, busy}, 64'd1);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        sb_pop(tag, hi, lo);
      end
    end
    chk({tag, "_done_latency"}, 64'(lat), 64'd32);
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {62'h0, busy, done}, 64'd0);
  endtask

  initial begin
    int lat, ndone;
    #1;
    chk("reset_state", {busy, done, hi, lo}, 66'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    alu_chk("add_ovf_pos",  4'b0101, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1);
    alu_chk("addu_no_ovf",  4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0);
    alu_chk("add_ovf_neg",  4'b0101, 32'h80000000, 32'h80000000, 32'h0,        1'b1);
    alu_chk("add_mixed",    4'b0101, 32'h5,        32'hFFFFFFFD, 32'h2,        1'b0);
    alu_chk("subu",         4'b0001, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0);
    alu_chk("subu_eq",      4'b0001, 32'h55,       32'h55,       32'h0,        1'b0);
    alu_chk("or",           4'b0010, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0);
    alu_chk("slt",          4'b0011, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0);
    alu_chk("sltu",         4'b1001, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0);
    alu_chk("lui",          4'b0100, 32'h0,        32'h12340000, 32'h12340000, 1'b0);
    alu_chk("and",          4'b0110, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0);
    alu_chk("xor",          4'b0111, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0);
    alu_chk("nor",          4'b1000, 32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0, 1'b0);
    alu_chk("mult_res0",    4'b1010, 32'h5,        32'h5,        32'h0,        1'b0);
    alu_op = 4'b0000;

    do_md("mult",  4'b1010, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    alu_chk("mfhi", 4'b1110, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
    alu_chk("mflo", 4'b1111, 32'h0, 32'h0, 32'hFFFFFFFA, 1'b0);
    do_md("multu", 4'b1011, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
    do_md("div_neg", 4'b1100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_md("divu_by0", 4'b1101, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF);
    do_md("div_min_m1", 4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    do_md("div_neg_by0", 4'b1100, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // Busy window: second op dropped, mflo returns pre-op LO
    @(negedge clk);
    op_valid = 1'b1; alu_op = 4'b1101; a_in = 32'd100; b_in = 32'd7;
    sb_q.push_back({32'd2, 32'd14});
    @(posedge clk); #1;
    op_valid = 1'b0; alu_op = 4'b0000;
    lat = 0; ndone = 0;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
        sb_pop("busy_divu", hi, lo);
      end
      if (k == 2) begin
        op_valid = 1'b1; alu_op = 4'b1010; a_in = 32'd5; b_in = 32'd5;
      end
      if (k == 3) begin
        op_valid = 1'b0; alu_op = 4'b0000;
      end
      if (k == 5) begin
        alu_op = 4'b1111; #1;
        chk("mflo_while_busy", {32'h0, alu_result}, {32'h0, last_lo});
        alu_op = 4'b0000;
      end
    end
    chk("busy_done_count", 64'(ndone), 64'd1);
    chk("busy_done_latency", 64'(lat), 64'd32);
    chk("busy_queue_empty", 64'(sb_q.size()), 64'd0);
    chk("busy_idle_end", {62'h0, busy, done}, 64'd0);

    // Reset mid-operation
    @(negedge clk);
    op_valid = 1'b1; alu_op = 4'b1100; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; alu_op = 4'b0000;
    for (int k = 1; k <= 10; k++) @(posedge clk);
    #3;
    chk("pre_reset_busy", {63'h0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("reset_abort", {busy, done, hi, lo}, 66'h0);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("reset_no_done", 64'(ndone), 64'd0);
    do_md("multu_after_rst", 4'b1011, 32'd3, 32'd4, 32'd0, 32'd12);

    // 16-bit build
    alu_op16 = 4'b0101; a16 = 16'hFFFF; b16 = 16'h0001;
    #1;
    chk("w16_add", {46'h0, res16, ovf16, zero16}, 64'h0);
    @(negedge clk);
    op_valid16 = 1'b1; alu_op16 = 4'b1011; a16 = 16'hFFFF; b16 = 16'hFFFF;
    sb_q.push_back({32'h0000FFFE, 32'h00000001});
    @(posedge clk); #1;
    op_valid16 = 1'b0; alu_op16 = 4'b0000;
    lat = 0;
    for (int k = 1; k <= 24 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done16) begin
        lat = k;
        sb_pop("w16_multu", {16'h0, hi16}, {16'h0, lo16});
      end
    end
    chk("w16_done_latency", 64'(lat), 64'd16);
    @(posedge clk); #1;
    chk("w16_idle_after", {62'h0, busy16, done16}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
